// File: rtl/button_pkg.sv
// Shared state type and 50 MHz timing defaults for the push-button conditioning path.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } button_state_t;

    localparam int CLK_HZ              = 50_000_000;
    localparam int DEBOUNCE_10MS       = CLK_HZ / 100;
    localparam int REPEAT_DELAY_500MS  = CLK_HZ / 2;
    localparam int REPEAT_PERIOD_100MS = CLK_HZ / 10;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Key-side bundle: raw pin toward the debouncer, conditioned level and strobes back.
interface button_debounce_if;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic repeat_pulse;

    modport master (output btn_raw,
                    input  btn_level, press_pulse, release_pulse, repeat_pulse);
    modport slave  (input  btn_raw,
                    output btn_level, press_pulse, release_pulse, repeat_pulse);
endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous bit; reset value is a parameter so
// the idle level of the source can be preloaded.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronise, qualify each edge with a stability count, and
// emit a clean level plus press/release/auto-repeat strobes, all registered.
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    button_debounce_if.slave   bus
);
    localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RPT_DLY = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RPT_PER = CW'(REPEAT_PERIOD);

    button_state_t state;
    logic [CW-1:0] db_cnt, rpt_cnt, rpt_inc;
    logic          rpt_armed, rpt_fire, rpt_run, release_ok;
    logic          btn_n, btn_s;
    logic          level_q, press_q, release_q, repeat_q;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    // Normalise before synchronising so the flops reset to "released" for either polarity.
    assign btn_n = bus.btn_raw ^ ACTIVE_LOW;

    sync2 #(.RST_VAL(1'b0)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_n),
        .q   (btn_s)
    );

    always_comb begin
        release_ok = (state == RELEASE_CHK) && !btn_s && (db_cnt >= DB_LAST);
        // Repeat phase keeps running through a rejected release bounce.
        rpt_run    = (state == PRESSED) || ((state == RELEASE_CHK) && !release_ok);
        rpt_inc    = sat_inc(rpt_cnt);
        rpt_fire   = (REPEAT_DELAY != 0) &&
                     (rpt_armed ? (rpt_inc == RPT_PER) : (rpt_inc == RPT_DLY));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RELEASED;
            db_cnt    <= '0;
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            case (state)
                RELEASED: if (btn_s) begin
                    state  <= PRESS_CHK;
                    db_cnt <= '0;
                end
                PRESS_CHK: begin
                    if (!btn_s) begin
                        state  <= RELEASED;
                        db_cnt <= '0;
                    end else if (db_cnt >= DB_LAST) begin
                        state     <= PRESSED;
                        level_q   <= 1'b1;
                        press_q   <= 1'b1;
                        rpt_cnt   <= '0;
                        rpt_armed <= 1'b0;
                    end else begin
                        db_cnt <= sat_inc(db_cnt);
                    end
                end
                PRESSED: if (!btn_s) begin
                    state  <= RELEASE_CHK;
                    db_cnt <= '0;
                end
                RELEASE_CHK: begin
                    if (btn_s) begin
                        state <= PRESSED;
                    end else if (release_ok) begin
                        state     <= RELEASED;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        db_cnt <= sat_inc(db_cnt);
                    end
                end
                default: state <= RELEASED;
            endcase

            if (rpt_run) begin
                rpt_cnt  <= rpt_fire ? '0 : rpt_inc;
                repeat_q <= rpt_fire;
                if (rpt_fire) rpt_armed <= 1'b1;
            end
        end
    end

    assign bus.btn_level     = level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.repeat_pulse  = repeat_q;
endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: a cycle table for the clean press/release, hand sequences for
// bounce, repeat and reset corners, and a random key pattern against a run-length model.
module tb_button_debounce;
    localparam int DEB = 4;
    localparam int DLY = 10;
    localparam int PER = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw_r = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    button_debounce_if bus();
    button_debounce_if bus0();
    assign bus.btn_raw  = raw_r;
    assign bus0.btn_raw = raw_r;

    button_debounce #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER),
                      .ACTIVE_LOW(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(0), .REPEAT_PERIOD(PER),
                      .ACTIVE_LOW(1'b1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    // Reference: a level flips once the synchronised key has disagreed with it for DEB+1
    // consecutive edges; repeats are derived from edges elapsed since acceptance.
    bit m_c1, m_c2, m_s, m_level, m_p, m_r, m_rp;
    int m_run, m_held;

    task automatic model_step();
        m_p = 1'b0; m_r = 1'b0; m_rp = 1'b0;
        if (rst) begin
            m_c1 = 1'b0; m_c2 = 1'b0; m_level = 1'b0; m_run = 0; m_held = 0;
        end else begin
            m_s  = m_c2;
            m_c2 = m_c1;
            m_c1 = ~raw_r;
            m_run = (m_s != m_level) ? m_run + 1 : 0;
            if (m_run == DEB + 1) begin
                m_level = ~m_level;
                m_run   = 0;
                if (m_level) begin m_p = 1'b1; m_held = 0; end
                else m_r = 1'b1;
            end else if (m_level) begin
                m_held++;
                if (m_held == DLY || (m_held > DLY && (m_held - DLY) % PER == 0)) m_rp = 1'b1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic rs);
        raw_r = r;
        rst   = rs;
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("model_level",   32'(bus.btn_level),     32'(m_level));
        chk("model_press",   32'(bus.press_pulse),   32'(m_p));
        chk("model_release", 32'(bus.release_pulse), 32'(m_r));
        chk("model_repeat",  32'(bus.repeat_pulse),  32'(m_rp));
        chk("nodelay_level", 32'(bus0.btn_level),    32'(m_level));
        chk("nodelay_repeat", 32'(bus0.repeat_pulse), 32'd0);
    endtask

    task automatic wait_press();
        int n;
        n = 0;
        do begin cyc(1'b0, 1'b0); n++; end while (!bus.press_pulse && n < 20);
        chk("press_within_budget", 32'(bus.press_pulse), 32'd1);
    endtask

    typedef struct {
        logic raw, rs, lvl, prs, rel, rpt;
    } vec_t;
    vec_t tab[31];

    initial begin
        int strobes, lvl_cnt, rel_cnt, k, len;
        logic v;
        logic [31:0] rmask, exp_rm;

        for (int i = 0; i < 31; i++) begin
            tab[i].rs  = (i < 2);
            tab[i].raw = !(i >= 5 && i < 22);
            tab[i].lvl = (i >= 11 && i < 28);
            tab[i].prs = (i == 11);
            tab[i].rel = (i == 28);
            tab[i].rpt = (i == 21 || i == 24 || i == 27);
        end

        @(negedge clk);
        for (int i = 0; i < 31; i++) begin
            cyc(tab[i].raw, tab[i].rs);
            chk($sformatf("tab%0d_level", i),   32'(bus.btn_level),     32'(tab[i].lvl));
            chk($sformatf("tab%0d_press", i),   32'(bus.press_pulse),   32'(tab[i].prs));
            chk($sformatf("tab%0d_release", i), 32'(bus.release_pulse), 32'(tab[i].rel));
            chk($sformatf("tab%0d_repeat", i),  32'(bus.repeat_pulse),  32'(tab[i].rpt));
        end

        // Bounce rejection: three cycles pressed, one released, five times over.
        strobes = 0; lvl_cnt = 0;
        for (int b = 0; b < 5; b++)
            for (int j = 0; j < 4; j++) begin
                cyc(j == 3, 1'b0);
                strobes += bus.press_pulse + bus.release_pulse + bus.repeat_pulse;
                lvl_cnt += bus.btn_level;
            end
        for (int j = 0; j < 8; j++) begin
            cyc(1'b1, 1'b0);
            strobes += bus.press_pulse + bus.release_pulse + bus.repeat_pulse;
            lvl_cnt += bus.btn_level;
        end
        chk("bounce_strobes", strobes, 0);
        chk("bounce_level", lvl_cnt, 0);

        // Hold 30 cycles with a 2-cycle release bounce early on.
        wait_press();
        rmask = '0; rel_cnt = 0; lvl_cnt = 0;
        for (int j = 1; j <= 30; j++) begin
            cyc(j == 5 || j == 6, 1'b0);
            if (bus.repeat_pulse) rmask[j] = 1'b1;
            rel_cnt += bus.release_pulse;
            lvl_cnt += !bus.btn_level;
        end
        exp_rm = '0;
        for (int t = DLY; t <= 30; t += PER) exp_rm[t] = 1'b1;
        chk("repeat_offsets", rmask, exp_rm);
        chk("hold_no_release", rel_cnt, 0);
        chk("hold_level_low_cycles", lvl_cnt, 0);
        for (int j = 0; j < 8; j++) cyc(1'b1, 1'b0);

        // Reset while pressed with the key still held.
        wait_press();
        for (int j = 0; j < 3; j++) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        chk("rst_level", 32'(bus.btn_level), 32'd0);
        chk("rst_press", 32'(bus.press_pulse), 32'd0);
        chk("rst_release", 32'(bus.release_pulse), 32'd0);
        chk("rst_repeat", 32'(bus.repeat_pulse), 32'd0);
        k = 0; rel_cnt = 0;
        do begin
            cyc(1'b0, 1'b0);
            k++;
            rel_cnt += bus.release_pulse;
        end while (!bus.press_pulse && k < 20);
        chk("rst_repress_latency", k, 7);
        chk("rst_no_release", rel_cnt, 0);
        for (int j = 0; j < 8; j++) cyc(1'b1, 1'b0);

        // Random key segments with occasional reset, checked against the model.
        for (int seg = 0; seg < 120; seg++) begin
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 20);
            for (int j = 0; j < len; j++) cyc(v, $urandom_range(0, 59) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
